// File: rtl/gapal_shift_pkg.sv
// Shared definitions for the GAPAL multi-cycle shift responder.
// Contents: default datapath widths, FSM state encoding, latched mode fields.
package gapal_shift_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned AMT_W_DEF = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Mode captured on the accept edge and held for the whole operation.
  typedef struct packed {
    logic rotate;
    logic left;
  } mode_t;

endpackage

// File: rtl/shift_step.sv
// One-bit combinational shift/rotate stage.
// Ports:
//   value_i  : current value
//   left_i   : 1 = toward MSB, 0 = toward LSB
//   rotate_i : 1 = wrap the vacated bit around, 0 = zero fill left / sign fill right
//   step_c   : value after one step (combinational)
module shift_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             left_i,
  input  logic             rotate_i,
  output logic [WIDTH-1:0] step_c
);

  logic fill_lsb;
  logic fill_msb;

  // Incoming bit: rotation wraps the outgoing bit; otherwise 0 on the left, sign on the right.
  assign fill_lsb = rotate_i ? value_i[WIDTH-1] : 1'b0;
  assign fill_msb = rotate_i ? value_i[0] : value_i[WIDTH-1];

  always_comb begin
    step_c = value_i;
    if (left_i) begin
      step_c = {value_i[WIDTH-2:0], fill_lsb};
    end else begin
      step_c = {fill_msb, value_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift responder: accepts a request on start, shifts one bit per
// cycle, pulses done with the result in r.
// Optional feature macro: SHIFT_ROTATE_EN (adds the rotate input).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : request strobe, accepted only when idle
//   shift_string : operand, sampled on accept
//   shift_amount : bit count, sampled on accept
//   left         : 1 = logical left, 0 = arithmetic right
//   rotate       : rotate select (SHIFT_ROTATE_EN builds only)
//   busy         : request in progress
//   done         : one-cycle completion pulse, r valid
//   r            : result, held until next accept or reset
module seq_shift_unit
  import gapal_shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] shift_string,
  input  logic [AMT_W-1:0] shift_amount,
  input  logic             left,
`ifdef SHIFT_ROTATE_EN
  input  logic             rotate,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d;
  mode_t            mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_c;
  logic             rotate_in;

`ifdef SHIFT_ROTATE_EN
  assign rotate_in = rotate;
`else
  assign rotate_in = 1'b0;
`endif

  // Single stage feeding the result register.
  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .value_i  (r_q),
    .left_i   (mode_q.left),
    .rotate_i (mode_q.rotate),
    .step_c   (step_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      r_q     <= '0;
      mode_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_SHIFT;
          r_d           = shift_string;
          count_d       = shift_amount;
          mode_d.left   = left;
          mode_d.rotate = rotate_in;
          busy_d        = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (count_q != '0) begin
          r_d     = step_c;
          count_d = AMT_W'(count_q - 1'b1);
        end else begin
          // Completion edge leaves r untouched so done and r line up.
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r    = r_q;

endmodule
